// File: rtl/hpm_window_sampler.sv
// HPM window sampler: counts two event streams per window and hands a
// frozen snapshot to the detector over an enable/done handshake.
module hpm_window_sampler #(
    parameter int WINDOW_CYCLES = 1024,
    parameter int TIMEOUT       = 16,
    parameter int ATK_W         = 16
) (
    input  logic             clk_h,
    input  logic             rst_h,
    input  logic             sampler_en,
    input  logic             ev0_i,
    input  logic             ev1_i,
    output logic [1:0][31:0] hpm_o,
    output logic             enable_o,
    input  logic             done_i,
    input  logic [1:0]       alert_i,
    output logic [1:0]       last_alert_o,
    output logic [ATK_W-1:0] atk_cnt_o,
    output logic             irq_o,
    input  logic             irq_clr_i,
    output logic             timeout_o
);

    localparam int TW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        COUNT,
        REQ,
        WAIT
    } state_t;

    state_t          state;
    logic [31:0]     live0;
    logic [31:0]     live1;
    logic [31:0]     next0;
    logic [31:0]     next1;
    logic [TW-1:0]   timer;
    logic [WW-1:0]   wcnt;
    logic            terminal;

    // Saturating increments; the snapshot uses these so the edge event counts.
    always_comb begin
        next0 = live0;
        next1 = live1;
        if (sampler_en && ev0_i && (live0 != 32'hFFFF_FFFF))
            next0 = live0 + 32'd1;
        if (sampler_en && ev1_i && (live1 != 32'hFFFF_FFFF))
            next1 = live1 + 32'd1;
    end

    assign terminal = (timer == TW'(WINDOW_CYCLES - 1));

    always_ff @(posedge clk_h or posedge rst_h) begin
        if (rst_h) begin
            state        <= COUNT;
            live0        <= '0;
            live1        <= '0;
            timer        <= '0;
            wcnt         <= '0;
            hpm_o        <= '0;
            enable_o     <= 1'b0;
            last_alert_o <= '0;
            atk_cnt_o    <= '0;
            irq_o        <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            live0    <= next0;
            live1    <= next1;
            enable_o <= 1'b0;
            if (sampler_en && !terminal)
                timer <= timer + 1'b1;
            // Clear first so a same-cycle set below takes priority.
            if (irq_clr_i) begin
                irq_o     <= 1'b0;
                timeout_o <= 1'b0;
            end
            unique case (state)
                COUNT: begin
                    if (terminal && sampler_en) begin
                        hpm_o    <= {next1, next0};
                        live0    <= '0;
                        live1    <= '0;
                        timer    <= '0;
                        enable_o <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_i) begin
                        last_alert_o <= alert_i;
                        if (alert_i != 2'b00) begin
                            irq_o <= 1'b1;
                            if (atk_cnt_o != {ATK_W{1'b1}})
                                atk_cnt_o <= atk_cnt_o + 1'b1;
                        end
                        state <= COUNT;
                    end else if (wcnt == WW'(TIMEOUT - 1)) begin
                        timeout_o <= 1'b1;
                        state     <= COUNT;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: state <= COUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_hpm_window_sampler.sv
// Scoreboard bench for hpm_window_sampler: directed cycle schedule pushes
// hand-computed snapshots; a monitor checks them on every enable_o pulse.
module tb_hpm_window_sampler;

    logic             clk_h = 1'b0;
    logic             rst_h;
    logic             sampler_en;
    logic             ev0_i;
    logic             ev1_i;
    logic [1:0][31:0] hpm_o;
    logic             enable_o;
    logic             done_i;
    logic [1:0]       alert_i;
    logic [1:0]       last_alert_o;
    logic [1:0]       atk_cnt_o;
    logic             irq_o;
    logic             irq_clr_i;
    logic             timeout_o;

    hpm_window_sampler #(
        .WINDOW_CYCLES(8),
        .TIMEOUT      (16),
        .ATK_W        (2)
    ) dut (
        .clk_h       (clk_h),
        .rst_h       (rst_h),
        .sampler_en  (sampler_en),
        .ev0_i       (ev0_i),
        .ev1_i       (ev1_i),
        .hpm_o       (hpm_o),
        .enable_o    (enable_o),
        .done_i      (done_i),
        .alert_i     (alert_i),
        .last_alert_o(last_alert_o),
        .atk_cnt_o   (atk_cnt_o),
        .irq_o       (irq_o),
        .irq_clr_i   (irq_clr_i),
        .timeout_o   (timeout_o)
    );

    always #5 clk_h = ~clk_h;

    typedef struct {
        logic [31:0] h0;
        logic [31:0] h1;
        logic [1:0]  la;
        logic [1:0]  atk;
        logic        irq;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   n_tot = 0;
    int   n_bad = 0;
    int   n_en  = 0;
    int   n_push = 0;
    logic prev_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tot++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic push(input logic [31:0] h0, input logic [31:0] h1, input logic [1:0] la,
                        input logic [1:0] atk, input logic irq, input logic to);
        exp_t e;
        e.h0 = h0; e.h1 = h1; e.la = la; e.atk = atk; e.irq = irq; e.to = to;
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hpm0"}, hpm_o[0], 32'd0);
        chk({tag, "_hpm1"}, hpm_o[1], 32'd0);
        chk({tag, "_en"}, {31'd0, enable_o}, 32'd0);
        chk({tag, "_la"}, {30'd0, last_alert_o}, 32'd0);
        chk({tag, "_atk"}, {30'd0, atk_cnt_o}, 32'd0);
        chk({tag, "_irq"}, {31'd0, irq_o}, 32'd0);
        chk({tag, "_to"}, {31'd0, timeout_o}, 32'd0);
    endtask

    always @(negedge clk_h) begin
        if (enable_o === 1'b1) begin
            exp_t e;
            n_en++;
            chk("enable_width", {31'd0, prev_en}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_enable", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("snap_hpm0", hpm_o[0], e.h0);
                chk("snap_hpm1", hpm_o[1], e.h1);
                chk("snap_last_alert", {30'd0, last_alert_o}, {30'd0, e.la});
                chk("snap_atk_cnt", {30'd0, atk_cnt_o}, {30'd0, e.atk});
                chk("snap_irq", {31'd0, irq_o}, {31'd0, e.irq});
                chk("snap_timeout", {31'd0, timeout_o}, {31'd0, e.to});
            end
        end
        prev_en = enable_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_h = 1'b1; sampler_en = 1'b1; ev0_i = 1'b0; ev1_i = 1'b0;
        done_i = 1'b0; alert_i = 2'b00; irq_clr_i = 1'b0;
        repeat (2) @(posedge clk_h);
        #1;
        chk_zero("rst_init");
        rst_h = 1'b0;

        for (int c = 0; c < 114; c++) begin
            sampler_en = !(c >= 97 && c <= 106);
            ev0_i = (c >= 2 && c <= 3) || (c >= 8 && c <= 23) ||
                    (c >= 64 && c <= 81) || (c >= 95 && c <= 112);
            ev1_i = (c <= 4) || (c == 32) || (c >= 82 && c <= 94);
            irq_clr_i = (c == 28) || (c == 33) || (c == 60) || (c == 85);
            done_i = 1'b0;
            alert_i = 2'b00;
            case (c)
                0:  begin done_i = 1'b1; alert_i = 2'b11; end
                9:  begin done_i = 1'b1; alert_i = 2'b00; end
                17: begin done_i = 1'b1; alert_i = 2'b10; end
                25: begin done_i = 1'b1; alert_i = 2'b00; end
                33: begin done_i = 1'b1; alert_i = 2'b01; end
                41: begin done_i = 1'b1; alert_i = 2'b11; end
                49: begin done_i = 1'b1; alert_i = 2'b10; end
                57: begin done_i = 1'b1; alert_i = 2'b01; end
                93: begin done_i = 1'b1; alert_i = 2'b00; end
                96: begin done_i = 1'b1; alert_i = 2'b00; end
                default: ;
            endcase
            @(posedge clk_h);
            #1;
            case (c)
                7:   push(2, 5, 2'b00, 2'd0, 1'b0, 1'b0);
                15:  push(8, 0, 2'b00, 2'd0, 1'b0, 1'b0);
                23:  push(8, 0, 2'b10, 2'd1, 1'b1, 1'b0);
                28: begin
                    chk("irq_clr", {31'd0, irq_o}, 32'd0);
                    chk("atk_kept", {30'd0, atk_cnt_o}, 32'd1);
                end
                31:  push(0, 0, 2'b00, 2'd1, 1'b0, 1'b0);
                39:  push(0, 1, 2'b01, 2'd2, 1'b1, 1'b0);
                47:  push(0, 0, 2'b11, 2'd3, 1'b1, 1'b0);
                55:  push(0, 0, 2'b10, 2'd3, 1'b1, 1'b0);
                63:  push(0, 0, 2'b01, 2'd3, 1'b0, 1'b0);
                79:  chk("timeout_early", {31'd0, timeout_o}, 32'd0);
                80:  chk("timeout_set", {31'd0, timeout_o}, 32'd1);
                81:  push(18, 0, 2'b01, 2'd3, 1'b0, 1'b1);
                89: begin
                    chk("wait_hold_hpm0", hpm_o[0], 32'd18);
                    chk("wait_hold_hpm1", hpm_o[1], 32'd0);
                end
                94:  push(0, 13, 2'b00, 2'd3, 1'b0, 1'b0);
                112: push(8, 0, 2'b00, 2'd3, 1'b0, 1'b0);
                default: ;
            endcase
        end

        chk("pre_rst_atk", {30'd0, atk_cnt_o}, 32'd3);
        rst_h = 1'b1;
        ev0_i = 1'b0; ev1_i = 1'b0;
        done_i = 1'b1; alert_i = 2'b11;
        #1;
        chk_zero("rst_mid");
        repeat (2) @(posedge clk_h);
        #1;
        rst_h = 1'b0;

        for (int d = 0; d < 12; d++) begin
            sampler_en = 1'b1;
            ev0_i = (d == 1) || (d == 3) || (d == 5);
            ev1_i = 1'b0;
            irq_clr_i = 1'b0;
            done_i = (d == 0) || (d == 9);
            alert_i = (d == 0) ? 2'b11 : 2'b00;
            @(posedge clk_h);
            #1;
            if (d == 7)
                push(3, 0, 2'b00, 2'd0, 1'b0, 1'b0);
        end
        done_i = 1'b0;
        repeat (2) @(posedge clk_h);
        #1;
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("enable_count", n_en, n_push);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
